// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with optional 2-entry skid buffer, flush,
// hazard taps of buffered destination registers and a saturating stall counter.
//
//   state | meaning
//   EMPTY | no entry buffered
//   ONE   | head valid, skid free
//   TWO   | head and skid valid, in_ready low
module pipe_stage_skid #(
    parameter int DATA_W = 128,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_regwr,
    input  logic [4:0]        in_wsel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_regwr,
    output logic [4:0]        out_wsel,
    output logic [4:0]        haz_wsel0,
    output logic [4:0]        haz_wsel1,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding is {skidV, headV}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t             state;
    logic               headV;
    logic               skidV;
    logic               inReadyQ;
    logic [DATA_W-1:0]  headData;
    logic               headRegwr;
    logic [4:0]         headWsel;
    logic [DATA_W-1:0]  skidData;
    logic               skidRegwr;
    logic [4:0]         skidWsel;
    logic [CNT_W-1:0]   stallCnt;
    logic               inXfer;
    logic               outXfer;

    assign headV   = state[0];
    assign skidV   = state[1];
    assign inXfer  = in_valid & in_ready;
    assign outXfer = headV & out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= EMPTY;
            inReadyQ  <= 1'b1;
            headData  <= '0;
            headRegwr <= 1'b0;
            headWsel  <= 5'd0;
            skidData  <= '0;
            skidRegwr <= 1'b0;
            skidWsel  <= 5'd0;
            stallCnt  <= '0;
        end else begin
            // A flushed cycle loads nothing; a coincident head handshake has already completed.
            if (flush) begin
                state    <= EMPTY;
                inReadyQ <= 1'b1;
            end else if (SKID) begin
                case (state)
                    EMPTY: begin
                        if (inXfer) begin
                            headData  <= in_data;
                            headRegwr <= in_regwr;
                            headWsel  <= in_wsel;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (inXfer && outXfer) begin
                            headData  <= in_data;
                            headRegwr <= in_regwr;
                            headWsel  <= in_wsel;
                        end else if (inXfer) begin
                            skidData  <= in_data;
                            skidRegwr <= in_regwr;
                            skidWsel  <= in_wsel;
                            state     <= TWO;
                            inReadyQ  <= 1'b0;
                        end else if (outXfer) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (outXfer) begin
                            headData  <= skidData;
                            headRegwr <= skidRegwr;
                            headWsel  <= skidWsel;
                            state     <= ONE;
                            inReadyQ  <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= EMPTY;
                        inReadyQ <= 1'b1;
                    end
                endcase
            end else begin
                if (inXfer) begin
                    headData  <= in_data;
                    headRegwr <= in_regwr;
                    headWsel  <= in_wsel;
                    state     <= ONE;
                end else if (outXfer) begin
                    state <= EMPTY;
                end
            end

            if (headV && !out_ready && !flush && (stallCnt != {CNT_W{1'b1}}))
                stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    // Without the skid entry, ready must look through to the consumer to keep full rate.
    assign in_ready  = SKID ? inReadyQ : (!headV || out_ready);
    assign out_valid = headV;
    assign out_data  = headData;
    assign out_regwr = headV & headRegwr;
    assign out_wsel  = headWsel;
    assign haz_wsel0 = (headV && headRegwr) ? headWsel : 5'd0;
    assign haz_wsel1 = (skidV && skidRegwr) ? skidWsel : 5'd0;
    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid (16-bit counter), no-skid and 4-bit-counter
// instances share one stimulus; the skid instance is also tracked by a scoreboard.
module tb_pipe_stage_skid;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_regwr;
    logic [4:0]    in_wsel;
    logic          out_ready;

    logic          aInReady, aOutValid, aOutRegwr;
    logic [DW-1:0] aOutData;
    logic [4:0]    aOutWsel, aHaz0, aHaz1;
    logic [15:0]   aStall;

    logic          bInReady, bOutValid, bOutRegwr;
    logic [DW-1:0] bOutData;
    logic [4:0]    bOutWsel, bHaz0, bHaz1;
    logic [15:0]   bStall;

    logic          cInReady, cOutValid, cOutRegwr;
    logic [DW-1:0] cOutData;
    logic [4:0]    cOutWsel, cHaz0, cHaz1;
    logic [3:0]    cStall;

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1), .CNT_W(16)) uSkid (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(aInReady), .in_data(in_data),
        .in_regwr(in_regwr), .in_wsel(in_wsel),
        .out_valid(aOutValid), .out_ready(out_ready), .out_data(aOutData),
        .out_regwr(aOutRegwr), .out_wsel(aOutWsel),
        .haz_wsel0(aHaz0), .haz_wsel1(aHaz1), .stall_cnt(aStall)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b0), .CNT_W(16)) uNoSkid (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(bInReady), .in_data(in_data),
        .in_regwr(in_regwr), .in_wsel(in_wsel),
        .out_valid(bOutValid), .out_ready(out_ready), .out_data(bOutData),
        .out_regwr(bOutRegwr), .out_wsel(bOutWsel),
        .haz_wsel0(bHaz0), .haz_wsel1(bHaz1), .stall_cnt(bStall)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1), .CNT_W(4)) uSat (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(cInReady), .in_data(in_data),
        .in_regwr(in_regwr), .in_wsel(in_wsel),
        .out_valid(cOutValid), .out_ready(out_ready), .out_data(cOutData),
        .out_regwr(cOutRegwr), .out_wsel(cOutWsel),
        .haz_wsel0(cHaz0), .haz_wsel1(cHaz1), .stall_cnt(cStall)
    );

    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(string name, int act, int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    // Scoreboard: payloads enter on accepted input, leave on consumed head.
    int sbQ[$];

    always @(negedge CLK) begin
        if (RST) begin
            sbQ.delete();
        end else begin
            if (aOutValid && out_ready) begin
                check("sb_has_entry", int'(sbQ.size() > 0), 1);
                if (sbQ.size() > 0) check("sb_out_data", int'(aOutData), sbQ.pop_front());
            end
            if (flush) sbQ.delete();
            else if (in_valid && aInReady) sbQ.push_back(int'(in_data));
        end
    end

    typedef struct {
        int iv; int d; int ws; int rw; int ordy; int fl;
        int eIr; int eOv; int eOd; int eRw; int eH0; int eH1; int eStall;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = '0;
        in_regwr  = 1'b0;
        in_wsel   = 5'd0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic doReset();
        idle();
        RST = 1'b1;
        #5;
        RST = 1'b0;
        step();
    endtask

    initial begin
        //          iv  d      ws rw or fl | ir ov od     rw h0 h1 stall
        vecs[0]  = '{1, 'h11, 5, 1, 0, 0,   1, 1, 'h11, 1, 5, 0, 0};
        vecs[1]  = '{1, 'h22, 9, 1, 0, 0,   0, 1, 'h11, 1, 5, 9, 1};
        vecs[2]  = '{1, 'h33, 3, 1, 0, 0,   0, 1, 'h11, 1, 5, 9, 2};
        vecs[3]  = '{1, 'h33, 3, 1, 0, 0,   0, 1, 'h11, 1, 5, 9, 3};
        vecs[4]  = '{1, 'h33, 3, 1, 1, 0,   1, 1, 'h22, 1, 9, 0, 3};
        vecs[5]  = '{1, 'h33, 3, 1, 1, 0,   1, 1, 'h33, 1, 3, 0, 3};
        vecs[6]  = '{0, 0,    0, 0, 1, 0,   1, 0, 'h33, 0, 0, 0, 3};
        vecs[7]  = '{1, 'h44, 7, 0, 0, 0,   1, 1, 'h44, 0, 0, 0, 3};
        vecs[8]  = '{1, 'h55, 8, 1, 0, 0,   0, 1, 'h44, 0, 0, 8, 4};
        vecs[9]  = '{1, 'h66, 6, 1, 1, 1,   1, 0, 'h44, 0, 0, 0, 4};
        vecs[10] = '{1, 'h77, 1, 1, 0, 0,   1, 1, 'h77, 1, 1, 0, 4};
        vecs[11] = '{0, 0,    0, 0, 0, 1,   1, 0, 'h77, 0, 0, 0, 4};
        vecs[12] = '{0, 0,    0, 0, 0, 0,   1, 0, 'h77, 0, 0, 0, 4};

        idle();
        RST = 1'b1;
        #2;
        check("rst_in_ready", int'(aInReady), 1);
        check("rst_out_valid", int'(aOutValid), 0);
        check("rst_out_data", int'(aOutData), 0);
        check("rst_out_regwr", int'(aOutRegwr), 0);
        check("rst_out_wsel", int'(aOutWsel), 0);
        check("rst_haz0", int'(aHaz0), 0);
        check("rst_haz1", int'(aHaz1), 0);
        check("rst_stall", int'(aStall), 0);
        check("rst_noskid_ready", int'(bInReady), 1);
        #4;
        RST = 1'b0;
        step();

        // Fill both entries, then reset asynchronously between edges.
        in_valid = 1'b1; in_data = 'hA; in_wsel = 5'd1; in_regwr = 1'b1; out_ready = 1'b0;
        step();
        in_data = 'hB; in_wsel = 5'd2;
        step();
        in_valid = 1'b0;
        check("two_in_ready", int'(aInReady), 0);
        check("two_out_data", int'(aOutData), 'hA);
        check("two_haz0", int'(aHaz0), 1);
        check("two_haz1", int'(aHaz1), 2);
        check("two_stall", int'(aStall), 1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_out_valid", int'(aOutValid), 0);
        check("arst_out_data", int'(aOutData), 0);
        check("arst_haz0", int'(aHaz0), 0);
        check("arst_haz1", int'(aHaz1), 0);
        check("arst_stall", int'(aStall), 0);
        check("arst_in_ready", int'(aInReady), 1);
        #2;
        RST = 1'b0;
        step();

        // Back-to-back streaming.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            in_wsel  = 5'(i);
            step();
            check("stream_data", int'(aOutData), i);
            check("stream_valid", int'(aOutValid), 1);
            check("stream_ready", int'(aInReady), 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", int'(aOutValid), 0);
        check("stream_stall", int'(aStall), 0);

        // Backpressure, regwr gating and flush sequences.
        doReset();
        for (int i = 0; i < 13; i++) begin
            in_valid  = 1'(vecs[i].iv);
            in_data   = DW'(vecs[i].d);
            in_wsel   = 5'(vecs[i].ws);
            in_regwr  = 1'(vecs[i].rw);
            out_ready = 1'(vecs[i].ordy);
            flush     = 1'(vecs[i].fl);
            step();
            check($sformatf("vec%0d_in_ready", i), int'(aInReady), vecs[i].eIr);
            check($sformatf("vec%0d_out_valid", i), int'(aOutValid), vecs[i].eOv);
            check($sformatf("vec%0d_out_data", i), int'(aOutData), vecs[i].eOd);
            check($sformatf("vec%0d_out_regwr", i), int'(aOutRegwr), vecs[i].eRw);
            check($sformatf("vec%0d_haz0", i), int'(aHaz0), vecs[i].eH0);
            check($sformatf("vec%0d_haz1", i), int'(aHaz1), vecs[i].eH1);
            check($sformatf("vec%0d_stall", i), int'(aStall), vecs[i].eStall);
        end
        idle();
        check("sb_left_empty", sbQ.size(), 0);

        // Single-register mode: combinational ready, replace head every cycle.
        doReset();
        check("ns_ready_empty", int'(bInReady), 1);
        in_valid = 1'b1; in_data = 'h5; in_wsel = 5'd4; in_regwr = 1'b1; out_ready = 1'b0;
        step();
        check("ns_head_valid", int'(bOutValid), 1);
        check("ns_head_data", int'(bOutData), 'h5);
        check("ns_haz0", int'(bHaz0), 4);
        check("ns_ready_full", int'(bInReady), 0);
        out_ready = 1'b1;
        #1;
        check("ns_ready_comb", int'(bInReady), 1);
        for (int d = 6; d <= 8; d++) begin
            in_data = DW'(d);
            step();
            check("ns_replace_data", int'(bOutData), d);
            check("ns_replace_valid", int'(bOutValid), 1);
            check("ns_haz1_zero", int'(bHaz1), 0);
        end
        in_valid = 1'b0;
        step();
        check("ns_drained", int'(bOutValid), 0);

        // Counter saturation.
        doReset();
        in_valid = 1'b1; in_data = 'h1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (14) step();
        check("sat_at14", int'(cStall), 14);
        repeat (6) step();
        check("sat_held", int'(cStall), 15);
        check("wide_cnt20", int'(aStall), 20);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline-stage register; the next generation of the fixed MEM/WB latch.
- Carries an opaque payload bundle (control + data fields packed by the instantiating stage) from producer stage to consumer stage using valid/ready handshake.
- Provides synchronous flush, an optional 2-entry skid buffer (registered ready, no combinational ready path), a hazard-unit tap of the buffered destination registers, and a saturating stall-cycle counter.

Parameters:
- DATA_W, 128, payload width in bits (packed stage bundle).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of stall counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- flush  input  1  discard all buffered entries this cycle.
- in_valid  input  1  producer has payload.
- in_ready  output  1  stage can accept payload.
- in_data  input  DATA_W  producer payload.
- in_regwr  input  1  payload writes register file.
- in_wsel  input  5  destination register of payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  DATA_W  head payload.
- out_regwr  output  1  head regwr (forced 0 when !out_valid).
- out_wsel  output  5  head destination register.
- haz_wsel0  output  5  wsel of head entry, 0 if head invalid or !regwr.
- haz_wsel1  output  5  wsel of skid entry, 0 if skid invalid or !regwr (always 0 when SKID=0).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (async, RST=1): all valid bits 0, out_data 0, out_wsel 0, out_regwr 0, haz_wsel0/1 0, stall_cnt 0, in_ready 1. Deassertion takes effect at the next CLK edge.
- Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both sampled at the rising edge.
- Latency: accepted payload appears on out_* the cycle after acceptance, when the buffer was empty or draining.
- SKID=1 states, encoded by {skid_v, head_v}:
  - EMPTY: in -> ONE.
  - ONE: in & out -> ONE (head replaced); in & !out -> TWO (new payload to skid); out & !in -> EMPTY.
  - TWO: out -> ONE (skid moves to head; in_ready was 0, so no in).
  - in_ready = !skid_v, registered; it is 0 only in TWO.
- SKID=0: head register only; in_ready = !head_v | out_ready (combinational); there is no TWO state.
- Ordering: strict FIFO; the skid entry never overtakes the head entry.
- Flush has priority over every other event. At the edge, both valid bits clear, and any in transfer in that cycle is discarded. in_ready does not depend on flush. The next state is EMPTY.
- Flush and out transfer in the same cycle: the consumer takes the head (the handshake completed); the buffer still ends EMPTY.
- Data registers load only on accept or skid-to-head move. out_data holds its last value when invalid. out_regwr and haz_* are gated by valid.
- stall_cnt increments by 1 on each edge where out_valid & !out_ready & !flush. It saturates at 2^CNT_W-1 and clears only on reset.
- Throughput: 1 payload/cycle in steady state with out_ready=1.

Test Plan:
1. Reset mid-TWO: fill both entries (in_data 0xA, 0xB with out_ready=0), assert RST asynchronously between edges -> out_valid, out_data, haz_wsel0/1 and stall_cnt go 0 immediately; in_ready=1.
2. Streaming, SKID=1: 8 back-to-back payloads 1..8 with out_ready=1 -> out_data 1..8 on consecutive cycles, first one cycle after acceptance; in_ready stays 1; stall_cnt=0.
3. Backpressure: out_ready=0; send 0x11 (wsel 5, regwr 1), then 0x22 (wsel 9, regwr 1) -> in_ready=0 after the second accept; haz_wsel0=5, haz_wsel1=9; third payload 0x33 is held at the producer. Raise out_ready -> 0x11, 0x22, 0x33 drain in order; stall_cnt equals the number of stalled cycles.
4. Flush in TWO with simultaneous in_valid and out_ready -> head consumed that cycle, next cycle out_valid=0, haz_wsel0/1=0, in_ready=1; the flushed in payload never appears.
5. SKID=0 mode: out_ready=0 with head full -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> head is replaced every cycle, no bubble.
6. Saturation, CNT_W=4: stall 20 cycles -> stall_cnt sticks at 15.
